ps2_keyboard_decoder: RTL



---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_keyboard_decoder_if.sv | 44 ++++
 rtl/ps2_rx_frame.sv | 170 +++++++++++++++++
 rtl/ps2_keyboard_decoder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard decoder:
//   - scancode constants for the keys the game controller tracks
//   - frame receiver FSM state encoding
//   - PS2_DATA_BITS, number of data bits in one PS/2 frame
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_keyboard_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder_if
// Bundles the keyboard pins, the decoded key outputs and the debug taps.
//   ps2_clk, ps2_data   raw keyboard pins (driven by the keyboard side)
//   enter_key           level, Enter held
//   key_release         1-cycle pulse, Enter released after being held
//   left/right/up/down  arrow key levels
//   frame_err           1-cycle pulse, frame dropped (parity/stop/timeout)
//   rx_state            frame receiver FSM state (debug)
//   byte_valid          1-cycle pulse, clean byte received (debug)
//   byte_data           the received byte, valid with byte_valid (debug)
// Handshake: byte_valid is a single-cycle strobe with no back-pressure; the
// consumer must take byte_data in the cycle byte_valid is high.
// Modports: master = keyboard/test side, slave = decoder.
// ---------------------------------------------------------------------------
interface ps2_keyboard_decoder_if;
    import ps2_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic       enter_key;
    logic       key_release;
    logic       left_key;
    logic       right_key;
    logic       up_key;
    logic       down_key;
    logic       frame_err;
    ps2_state_e rx_state;
    logic       byte_valid;
    logic [7:0] byte_data;

    modport master (
        output ps2_clk, ps2_data,
        input  enter_key, key_release, left_key, right_key, up_key, down_key,
        input  frame_err, rx_state, byte_valid, byte_data
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output enter_key, key_release, left_key, right_key, up_key, down_key,
        output frame_err, rx_state, byte_valid, byte_data
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 frame receiver: 2-FF synchronizers, ps2_clk glitch filter, falling
// edge strobe, frame FSM (start, 8 data bits LSB first, odd parity, stop)
// and an in-frame inactivity timeout.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   ps2_clk_i, ps2_data_i   raw asynchronous keyboard pins
//   byte_valid_o            1-cycle pulse, clean frame received
//   byte_data_o             received byte, valid with byte_valid_o
//   frame_err_o             1-cycle pulse, frame dropped
//   state_o                 current FSM state (debug)
// ---------------------------------------------------------------------------
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o,
    output ps2_state_e state_o
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronizers reset high so a reset never looks like a clock edge.
    logic clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;

    logic             filt_q, filt_d;
    logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic             strobe;

    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data_i;
            data_s2_q <= data_s1_q;
        end
    end

    // Glitch filter: the filtered level follows the synchronized clock only
    // after FILTER_LEN consecutive samples disagree with it. The strobe fires
    // in the cycle the filtered level is about to fall.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        strobe     = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                strobe = ~clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Frame FSM with timeout. A strobe always takes priority over timeout
    // expiry and clears the counter.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;
        if (strobe) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        err_d     = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    // Odd parity: XOR of data and parity bit must be 1.
                    if ((^shift_q ^ data_s2_q) != 1'b1) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s2_q && !err_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;
    assign state_o      = state_q;

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder
// Turns PS/2 scancodes into key levels and the Enter release strobe used by
// the game controller.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   bus          ps2_keyboard_decoder_if.slave: keyboard pins in, key
//                levels / key_release / frame_err out, debug taps out
// ---------------------------------------------------------------------------
module ps2_keyboard_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    ps2_keyboard_decoder_if.slave        bus
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    ps2_state_e rx_state;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err),
        .state_o      (rx_state)
    );

    logic ext_q, ext_d;
    logic brk_q, brk_d;
    logic enter_q, enter_d;
    logic key_release_q, key_release_d;
    logic left_q, left_d;
    logic right_q, right_d;
    logic up_q, up_d;
    logic down_q, down_d;

    // Prefix bytes only set flags; any other byte is a key code that consumes
    // them. A make for an already-held key just rewrites the level high.
    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        enter_d       = enter_q;
        key_release_d = 1'b0;
        left_d        = left_q;
        right_d       = right_q;
        up_d          = up_q;
        down_d        = down_q;
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (byte_data == SC_EXT) begin
                ext_d = 1'b1;
            end else if (byte_data == SC_BREAK) begin
                brk_d = 1'b1;
            end else begin
                if (!ext_q) begin
                    if (byte_data == SC_ENTER) begin
                        enter_d       = ~brk_q;
                        key_release_d = brk_q & enter_q;
                    end
                end else begin
                    case (byte_data)
                        SC_LEFT:  left_d  = ~brk_q;
                        SC_RIGHT: right_d = ~brk_q;
                        SC_UP:    up_d    = ~brk_q;
                        SC_DOWN:  down_d  = ~brk_q;
                        default:  ;
                    endcase
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            enter_q       <= 1'b0;
            key_release_q <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            up_q          <= 1'b0;
            down_q        <= 1'b0;
        end else begin
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            enter_q       <= enter_d;
            key_release_q <= key_release_d;
            left_q        <= left_d;
            right_q       <= right_d;
            up_q          <= up_d;
            down_q        <= down_d;
        end
    end

    assign bus.enter_key   = enter_q;
    assign bus.key_release = key_release_q;
    assign bus.left_key    = left_q;
    assign bus.right_key   = right_q;
    assign bus.up_key      = up_q;
    assign bus.down_key    = down_q;
    assign bus.frame_err   = frame_err;
    assign bus.rx_state    = rx_state;
    assign bus.byte_valid  = byte_valid;
    assign bus.byte_data   = byte_data;

endmodule
